sobel_stream: RTL and testbench

SOBEL_STREAM -- requirements
Module: sobel_stream

---
 rtl/sobel_stream_if.sv | 24 ++
 rtl/sobel_stream.sv | 157 +++++++++++++++
 tb/tb_sobel_stream.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_if.sv
// Streaming handshake bundle for the Sobel filter: pixel input, filtered output and frame status.
// The filter side uses the slave modport, the pixel source/sink side uses master.
interface sobel_stream_if #(
  parameter int PIX_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;
  logic             frame_done;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, frame_done
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, frame_done
  );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter with zero padding, two line buffers and a single output register.
//
// state | meaning
// FILL  | accept the first IMG_W+1 pixels of a frame, no output yet
// RUN   | one pixel in, one filtered pixel out
// FLUSH | no input, drain the last IMG_W+1 outputs, then a frame_done cycle
module sobel_stream #(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int MAG_MODE = 0,
  parameter int THRESH   = 128
) (
  input logic           clk,
  input logic           reset,
  sobel_stream_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t           state;
  logic [CW-1:0]    in_col, out_col;
  logic [RW-1:0]    in_row, out_row;
  logic [FW-1:0]    flush_left;
  logic             m_valid_q, m_last_q, frame_done_q;
  logic [PIX_W-1:0] m_data_q;

  logic [PIX_W-1:0] lb_a [IMG_W];
  logic [PIX_W-1:0] lb_b [IMG_W];

  // Two registered window columns; the third (right) column is the one arriving this step.
  logic [2:0][PIX_W-1:0]      col_l, col_c, col_new;
  logic [2:0][2:0][PIX_W-1:0] mp;
  logic [2:0]                 row_ok, col_ok;

  logic             s_ready_c, accept, slot_free, flush_step, step, produce;
  logic [PIX_W-1:0] pix_in;
  logic [PIX_W+1:0] sum_l, sum_r, sum_t, sum_b, abs_gx, abs_gy;
  logic [PIX_W+2:0] mag;
  logic [PIX_W-1:0] res;

  function automatic logic [PIX_W+1:0] wsum(input logic [PIX_W-1:0] a, b, c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  always_comb begin
    s_ready_c  = (state == FILL) || ((state == RUN) && (!m_valid_q || bus.m_ready));
    accept     = s_ready_c && bus.s_valid;
    slot_free  = !m_valid_q || bus.m_ready;
    flush_step = (state == FLUSH) && (flush_left != '0) && slot_free;
    step       = accept || flush_step;
    produce    = (accept && (state == RUN)) || flush_step;
    pix_in     = (state == FLUSH) ? '0 : bus.s_data;
    col_new    = {pix_in, lb_a[in_col], lb_b[in_col]};
  end

  // Border masks zero every neighbour outside the image, including wrapped line ends.
  always_comb begin
    row_ok = {out_row != RW'(IMG_H - 1), 1'b1, out_row != '0};
    col_ok = {out_col != CW'(IMG_W - 1), 1'b1, out_col != '0};
    mp     = '0;
    for (int r = 0; r < 3; r++) begin
      mp[r][0] = (row_ok[r] && col_ok[0]) ? col_l[r]   : '0;
      mp[r][1] = row_ok[r]                ? col_c[r]   : '0;
      mp[r][2] = (row_ok[r] && col_ok[2]) ? col_new[r] : '0;
    end
  end

  always_comb begin
    sum_l  = wsum(mp[0][0], mp[1][0], mp[2][0]);
    sum_r  = wsum(mp[0][2], mp[1][2], mp[2][2]);
    sum_t  = wsum(mp[0][0], mp[0][1], mp[0][2]);
    sum_b  = wsum(mp[2][0], mp[2][1], mp[2][2]);
    abs_gx = (sum_l >= sum_r) ? sum_l - sum_r : sum_r - sum_l;
    abs_gy = (sum_t >= sum_b) ? sum_t - sum_b : sum_b - sum_t;
    mag    = {1'b0, abs_gx} + {1'b0, abs_gy};
    res    = '0;
    if (MAG_MODE == 0) res = (|mag[PIX_W+2:PIX_W]) ? '1 : mag[PIX_W-1:0];
    else               res = (mag >= (PIX_W+3)'(THRESH)) ? '1 : '0;
  end

  always_ff @(posedge clk) begin
    if (step) begin
      lb_b[in_col] <= lb_a[in_col];
      lb_a[in_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FILL;
      in_col       <= '0;
      in_row       <= '0;
      out_col      <= '0;
      out_row      <= '0;
      flush_left   <= '0;
      col_l        <= '0;
      col_c        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
      if (step) begin
        col_l  <= col_c;
        col_c  <= col_new;
        in_col <= (in_col == CW'(IMG_W - 1)) ? '0 : in_col + 1'b1;
        if ((state != FLUSH) && (in_col == CW'(IMG_W - 1)))
          in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + 1'b1;
      end
      if (produce) begin
        m_valid_q <= 1'b1;
        m_data_q  <= res;
        m_last_q  <= (state == FLUSH) && (flush_left == FW'(1));
        out_col   <= (out_col == CW'(IMG_W - 1)) ? '0 : out_col + 1'b1;
        if (out_col == CW'(IMG_W - 1))
          out_row <= (out_row == RW'(IMG_H - 1)) ? '0 : out_row + 1'b1;
      end
      case (state)
        FILL:
          if (accept && (in_row == RW'(1)) && (in_col == '0)) state <= RUN;
        RUN:
          if (accept && (in_row == RW'(IMG_H - 1)) && (in_col == CW'(IMG_W - 1))) begin
            state      <= FLUSH;
            flush_left <= FW'(IMG_W + 1);
          end
        FLUSH: begin
          if (flush_step) flush_left <= flush_left - 1'b1;
          if (m_valid_q && bus.m_ready && m_last_q) frame_done_q <= 1'b1;
          // Hold off new input through the frame_done cycle, then start a fresh frame.
          if (frame_done_q) begin
            state   <= FILL;
            in_col  <= '0;
            in_row  <= '0;
            out_col <= '0;
            out_row <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_last     = m_last_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Directed and randomized-handshake bench for sobel_stream on a 4x4 image, magnitude and edge-map modes.
module tb_sobel_stream;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  int   early_acc = 0;

  logic [7:0] in_q [$];
  int         exp0_q [$];
  int         exp1_q [$];
  logic [7:0] frm [16];

  int g10_0  [16] = '{60, 40, 40, 60, 40, 0, 0, 40, 40, 0, 0, 40, 60, 40, 40, 60};
  int g10_1  [16] = '{255, 0, 0, 255, 0, 0, 0, 0, 0, 0, 0, 0, 255, 0, 0, 255};
  int g255   [16] = '{255, 255, 255, 255, 255, 0, 0, 255, 255, 0, 0, 255, 255, 255, 255, 255};

  sobel_stream_if #(.PIX_W(8)) bus0 ();
  sobel_stream_if #(.PIX_W(8)) bus1 ();

  assign bus1.s_valid = bus0.s_valid;
  assign bus1.s_data  = bus0.s_data;
  assign bus1.m_ready = bus0.m_ready;

  sobel_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .MAG_MODE(0), .THRESH(128))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  sobel_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .MAG_MODE(1), .THRESH(50))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && bus0.frame_done) begin
      fd_cnt++;
      if (bus0.s_ready) early_acc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int px(input int r, input int c);
    if (r < 0 || r > 3 || c < 0 || c > 3) return 0;
    return int'(frm[r*4 + c]);
  endfunction

  function automatic int ref_mag(input int r, input int c);
    int gx, gy;
    gx = (px(r-1, c-1) + 2*px(r, c-1) + px(r+1, c-1)) - (px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1));
    gy = (px(r-1, c-1) + 2*px(r-1, c) + px(r-1, c+1)) - (px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1));
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int gap_max);
    int gap, wait_cyc;
    logic hs;
    for (int i = 0; i < n; i++) begin
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      bus0.s_data  = in_q.pop_front();
      bus0.s_valid = 1'b1;
      hs = 1'b0;
      wait_cyc = 0;
      while (!hs) begin
        @(negedge clk);
        hs = bus0.s_ready;
        @(posedge clk);
        #1;
        wait_cyc++;
        if (!hs && wait_cyc > 300) begin
          checks++;
          errors++;
          $error("FAIL tx_timeout: observed no accept after %0d cycles, expected accept of pixel %0d", wait_cyc, i);
          bus0.s_valid = 1'b0;
          return;
        end
      end
      bus0.s_valid = 1'b0;
    end
  endtask

  task automatic receive(input int n, input int rdy_pct, input int stall_at);
    int wait_cyc;
    logic got, lst;
    logic [7:0] d0, d1;
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        bus0.m_ready = 1'b0;
        wait_cyc = 0;
        got = 1'b0;
        while (!got && wait_cyc < 400) begin
          @(negedge clk);
          got = bus0.m_valid;
          if (!got) begin
            @(posedge clk);
            #1;
          end
          wait_cyc++;
        end
        repeat (5) begin
          @(posedge clk);
          #1;
          @(negedge clk);
          chk("stall_m_valid", bus0.m_valid, 1);
          chk("stall_m_data", bus0.m_data, exp0_q[0]);
          chk("stall_s_ready", bus0.s_ready, 0);
        end
        @(posedge clk);
        #1;
      end
      got = 1'b0;
      wait_cyc = 0;
      d0 = '0;
      d1 = '0;
      lst = 1'b0;
      while (!got) begin
        bus0.m_ready = ($urandom_range(1, 100) <= rdy_pct);
        @(negedge clk);
        if (bus0.m_valid && bus0.m_ready) begin
          got = 1'b1;
          d0  = bus0.m_data;
          d1  = bus1.m_data;
          lst = bus0.m_last;
        end
        @(posedge clk);
        #1;
        wait_cyc++;
        if (!got && wait_cyc > 400) begin
          checks++;
          errors++;
          $error("FAIL rx_timeout: observed no output after %0d cycles, expected output %0d", wait_cyc, k);
          bus0.m_ready = 1'b0;
          return;
        end
      end
      chk("m_data_mag", d0, exp0_q.pop_front());
      chk("m_data_edge", d1, exp1_q.pop_front());
      chk("m_last", lst, (k % 16) == 15);
    end
    bus0.m_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus0.s_valid = 1'b0;
    bus0.s_data  = '0;
    bus0.m_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", bus0.m_valid, 0);
    chk("rst_m_data", bus0.m_data, 0);
    chk("rst_m_last", bus0.m_last, 0);
    chk("rst_frame_done", bus0.frame_done, 0);
    chk("rst_m_valid_edge", bus1.m_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", bus0.s_ready, 1);
    @(posedge clk);
    #1;

    // Flat frame of 10s, no stalls
    for (int i = 0; i < 16; i++) begin
      in_q.push_back(8'd10);
      exp0_q.push_back(g10_0[i]);
      exp1_q.push_back(g10_1[i]);
    end
    fork
      send(16, 0);
      receive(16, 100, -1);
    join
    settle();
    chk("frame_done_count_1", fd_cnt, 1);

    // Same frame with a 5-cycle m_ready stall in the middle
    for (int i = 0; i < 16; i++) begin
      in_q.push_back(8'd10);
      exp0_q.push_back(g10_0[i]);
      exp1_q.push_back(g10_1[i]);
    end
    fork
      send(16, 0);
      receive(16, 100, 3);
    join
    settle();
    chk("frame_done_count_2", fd_cnt, 2);

    // Saturating frame of 255s
    for (int i = 0; i < 16; i++) begin
      in_q.push_back(8'd255);
      exp0_q.push_back(g255[i]);
      exp1_q.push_back(g255[i]);
    end
    fork
      send(16, 0);
      receive(16, 100, -1);
    join
    settle();
    chk("frame_done_count_3", fd_cnt, 3);

    // Reset after 7 accepted pixels, then a clean frame
    for (int i = 0; i < 7; i++) in_q.push_back(8'd200);
    bus0.m_ready = 1'b1;
    send(7, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_m_valid", bus0.m_valid, 0);
    chk("midrst_m_valid_edge", bus1.m_valid, 0);
    chk("midrst_m_last", bus0.m_last, 0);
    chk("midrst_frame_done", bus0.frame_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus0.m_ready = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", bus0.s_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      in_q.push_back(8'd10);
      exp0_q.push_back(g10_0[i]);
      exp1_q.push_back(g10_1[i]);
    end
    fork
      send(16, 0);
      receive(16, 100, -1);
    join
    settle();
    chk("frame_done_count_4", fd_cnt, 4);

    // Two random frames back-to-back with random valid/ready
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        frm[i] = 8'($urandom_range(0, 255));
        in_q.push_back(frm[i]);
      end
      for (int i = 0; i < 16; i++) begin
        int m;
        m = ref_mag(i / 4, i % 4);
        exp0_q.push_back(m > 255 ? 255 : m);
        exp1_q.push_back(m >= 50 ? 255 : 0);
      end
    end
    fork
      send(32, 2);
      receive(32, 60, -1);
    join
    settle();
    chk("frame_done_count_6", fd_cnt, 6);
    chk("accept_during_frame_done", early_acc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
